// File: rtl/pool_tile_scheduler.sv
// Tile sequencer for the pooling filter: queues tile descriptors, drives the filter's
// metadata and start pulse, waits for done, counts tiles and watches for hangs.
module pool_tile_scheduler #(
    parameter int POOLING_UNITS  = 3,
    parameter int LIN_WIDTH      = 10,
    parameter int UNIT_STRIDE    = 2,
    parameter int DESC_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                               clk,
    input  logic                               res,
    input  logic                               desc_valid,
    output logic                               desc_ready,
    input  logic [LIN_WIDTH-1:0]               desc_base,
    input  logic [1:0]                         desc_fsize,
    input  logic [1:0]                         desc_op,
    input  logic                               desc_last,
    output logic [POOLING_UNITS*LIN_WIDTH-1:0] pf_start_addr,
    output logic [1:0]                         pf_filter_size,
    output logic [1:0]                         pf_op_type,
    output logic                               pf_valid_in,
    input  logic                               pf_done,
    input  logic                               abort,
    input  logic                               err_clear,
    output logic                               busy,
    output logic                               tile_done,
    output logic                               frame_done,
    output logic                               err,
    output logic [15:0]                        tile_count
);

    localparam int PTR_W = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        WAIT_DONE,
        FINISH,
        ERR
    } state_t;

    state_t state;
    state_t state_next;

    logic [LIN_WIDTH-1:0] fifo_base  [DESC_DEPTH];
    logic [1:0]           fifo_fsize [DESC_DEPTH];
    logic [1:0]           fifo_op    [DESC_DEPTH];
    logic                 fifo_last  [DESC_DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic full;
    logic empty;
    logic abort_hit;
    logic flush;
    logic push;
    logic pop;

    logic [WD_W-1:0] watchdog;
    logic            timeout_hit;
    logic            cur_last;

    logic [POOLING_UNITS*LIN_WIDTH-1:0] load_addr;

    assign full        = (count == CNT_W'(DESC_DEPTH));
    assign empty       = (count == '0);
    assign desc_ready  = !full;
    assign abort_hit   = abort && (state != ERR);
    assign flush       = abort_hit || (state == ERR);
    assign push        = desc_valid && !full && !flush;
    assign pop         = (state == LOAD) && !flush;
    assign timeout_hit = (watchdog == WD_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_base[wr_ptr]  <= desc_base;
            fifo_fsize[wr_ptr] <= desc_fsize;
            fifo_op[wr_ptr]    <= desc_op;
            fifo_last[wr_ptr]  <= desc_last;
        end
    end

    // Simultaneous push and pop leave the occupancy unchanged.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Each unit's start address is offset from the tile base and wraps within LIN_WIDTH.
    always_comb begin
        load_addr = '0;
        for (int u = 0; u < POOLING_UNITS; u++) begin
            load_addr[u*LIN_WIDTH +: LIN_WIDTH] = fifo_base[rd_ptr] + LIN_WIDTH'(u * UNIT_STRIDE);
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pf_start_addr  <= '0;
            pf_filter_size <= '0;
            pf_op_type     <= '0;
            cur_last       <= 1'b0;
        end else if (pop) begin
            pf_start_addr  <= load_addr;
            pf_filter_size <= fifo_fsize[rd_ptr];
            pf_op_type     <= fifo_op[rd_ptr];
            cur_last       <= fifo_last[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = ARM;
            end
            ARM: begin
                if (!pf_done) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (pf_done) begin
                    state_next = FINISH;
                end else if (timeout_hit) begin
                    state_next = ERR;
                end
            end
            FINISH: begin
                state_next = empty ? IDLE : LOAD;
            end
            ERR: begin
                if (err_clear) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort_hit) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            watchdog <= '0;
        end else if (state == ARM) begin
            watchdog <= '0;
        end else if (state == WAIT_DONE) begin
            watchdog <= watchdog + WD_W'(1);
        end
    end

    // An abort suppresses the start pulse and the completion pulses of the tile it kills.
    assign pf_valid_in = (state == ARM) && !pf_done && !abort;
    assign tile_done   = (state == FINISH) && !abort;
    assign frame_done  = tile_done && cur_last;
    assign busy        = (state != IDLE);
    assign err         = (state == ERR);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            tile_count <= '0;
        end else if (abort_hit) begin
            tile_count <= '0;
        end else if (tile_done) begin
            tile_count <= tile_count + 16'd1;
        end
    end

endmodule
